serial_add_arbiter: RTL and testbench
=====================================

Name: serial_add_arbiter

Overview:
- Shares one 1-bit full-adder cell (full_adder_1: i_a, i_b, i_Cin → o_s, o_Cout) between two requesters.
- Each requester submits a WIDTH-bit add (a + b + cin) through a valid/ready handshake.
- A round-robin arbiter grants one requester at a time.
- A sequencer then drives the shared cell bit-serially, LSB first, holding the carry in a flop, and returns the sum, carry-out and requester ID.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req0_valid  in  1  requester 0 has an operation pending.
- i_req0_a  in  WIDTH  requester 0 operand a.
- i_req0_b  in  WIDTH  requester 0 operand b.
- i_req0_cin  in  1  requester 0 carry-in.
- o_req0_ready  out  1  requester 0 operands accepted this cycle when high with valid.
- i_req1_valid, i_req1_a, i_req1_b, i_req1_cin, o_req1_ready: same as requester 0, for requester 1.
- o_res_valid  out  1  result strobe, exactly one cycle.
- o_res_id  out  1  requester that owns the result (0/1).
- o_res_sum  out  WIDTH  sum[WIDTH-1:0].
- o_res_cout  out  1  final carry-out.
- o_busy  out  1  high in ADD and DONE.

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE, carry=0, bit counter=0, sum register=0, last_grant=1 (so req0 wins first).
  - All outputs 0.
- States: IDLE, ADD, DONE.
- IDLE:
  - Arbiter is combinational on the valids.
  - Only one valid high: grant it.
  - Both high: grant the requester != last_grant.
  - None high: no grant; stay in IDLE.
  - o_reqN_ready=1 only for the granted N, only in IDLE. The other ready is 0.
  - On valid&ready:
    - Latch a, b into shift registers; carry←cin; id←N; last_grant←N; counter←0.
    - Go to ADD.
- ADD:
  - Each cycle, the cell gets a_sr[0], b_sr[0], carry.
  - sum_sr shifts right with o_s inserted at the MSB; carry←o_Cout.
  - a_sr and b_sr shift right; counter++.
  - After the WIDTH-th bit (counter==WIDTH-1 this cycle), go to DONE.
  - Both readys stay 0 throughout ADD and DONE; requesters hold their valids.
- DONE:
  - o_res_valid=1 for one cycle, with o_res_sum=sum_sr, o_res_cout=carry, o_res_id=id.
  - Next cycle: IDLE.
  - No result backpressure; the consumer must sample on the strobe.
- Result register outputs (sum, cout, id) hold their value after DONE until the next DONE.
- Latency and throughput:
  - Handshake in cycle T → o_res_valid in cycle T+WIDTH+1.
  - Next accept possible in cycle T+WIDTH+2; one operation per WIDTH+2 cycles.
- Arithmetic:
  - {o_res_cout, o_res_sum} = a + b + cin, exact, WIDTH+1 bits.
  - Wrap-around is reported only via cout.
- Boundary conditions:
  - A valid that deasserts in IDLE before ready is simply not served.
  - Operand changes during ADD are ignored, since operands were captured at accept.
  - i_rst asserted mid-ADD or in DONE:
    - Aborts immediately; no o_res_valid is produced.
    - last_grant returns to 1.
  - With both requesters continuously valid, grants strictly alternate 0,1,0,1…; no starvation.

Test Plan:
- Single op: req0 a=8'h3C, b=8'h05, cin=0 accepted at T → o_res_valid at T+9 with sum=8'h41, cout=0, id=0; o_busy high T+1..T+9.
- Overflow with carry-in: req1 a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1, id=1. Then a=8'h80, b=8'h7F, cin=1 → sum=8'h00, cout=1.
- Simultaneous requests right after reset: both valid (req0 1+2, req1 10+20) → req0 served first (sum=8'h03), then req1 (sum=8'h1E). Readys are never both high in one cycle.
- Fairness: both valid continuously for 6 operations → o_res_id sequence 0,1,0,1,0,1, each strobe 10 cycles apart.
- Reset mid-operation: i_rst pulsed on the 4th ADD cycle of req0 op → outputs 0, no o_res_valid. After release, a fresh req1 op completes normally and the first contested grant goes to req0.
- Exhaustive at WIDTH=2: all a, b, cin combinations (32 ops) on alternating requesters → {cout,sum} == a+b+cin for every op.

Source files
------------

// File: rtl/serial_add_arbiter.sv
// Two requesters share one 1-bit full-adder cell. A round-robin arbiter picks
// a requester and a sequencer adds the operands bit-serially, LSB first.

module full_adder_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_Cin,
    output logic o_s,
    output logic o_Cout
);
    assign o_s    = i_a ^ i_b ^ i_Cin;
    assign o_Cout = (i_a & i_b) | (i_Cin & (i_a ^ i_b));
endmodule

module serial_add_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req0_cin,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic             i_req1_cin,
    output logic             o_req1_ready,
    output logic             o_res_valid,
    output logic             o_res_id,
    output logic [WIDTH-1:0] o_res_sum,
    output logic             o_res_cout,
    output logic             o_busy
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic [WIDTH-1:0]   sum_nxt_c;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               id;
    logic               last_grant;
    logic               grant0_c;
    logic               grant1_c;
    logic               accept_c;
    logic               last_bit_c;
    logic               fa_s;
    logic               fa_cout;

    full_adder_1 u_fa (
        .i_a    (a_sr[0]),
        .i_b    (b_sr[0]),
        .i_Cin  (carry),
        .o_s    (fa_s),
        .o_Cout (fa_cout)
    );

    // Round-robin arbitration; only offered while idle and out of reset.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (state == S_IDLE && !i_rst) begin
            if (i_req0_valid && i_req1_valid) begin
                grant0_c = last_grant;
                grant1_c = ~last_grant;
            end else begin
                grant0_c = i_req0_valid;
                grant1_c = i_req1_valid;
            end
        end
    end

    assign o_req0_ready = grant0_c;
    assign o_req1_ready = grant1_c;
    assign accept_c     = grant0_c | grant1_c;
    assign last_bit_c   = (cnt == CNT_W'(WIDTH - 1));
    assign sum_nxt_c    = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept_c) state_nxt = S_ADD;
            S_ADD:   if (last_bit_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Operand capture, bit-serial datapath and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            id          <= 1'b0;
            last_grant  <= 1'b1;
            o_res_valid <= 1'b0;
            o_res_id    <= 1'b0;
            o_res_sum   <= '0;
            o_res_cout  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        a_sr       <= grant1_c ? i_req1_a   : i_req0_a;
                        b_sr       <= grant1_c ? i_req1_b   : i_req0_b;
                        carry      <= grant1_c ? i_req1_cin : i_req0_cin;
                        id         <= grant1_c;
                        last_grant <= grant1_c;
                        cnt        <= '0;
                    end
                end
                S_ADD: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_nxt_c;
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit_c) begin
                        o_res_sum  <= sum_nxt_c;
                        o_res_cout <= fa_cout;
                        o_res_id   <= id;
                    end
                end
                default: ;
            endcase
            o_res_valid <= (state == S_ADD) && last_bit_c;
            o_busy      <= (state_nxt != S_IDLE);
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Randomized and directed bench for serial_add_arbiter at WIDTH=8 and WIDTH=2,
// checked every cycle against a countdown/arithmetic reference model.

module tb_serial_add_arbiter;
    localparam int unsigned W0 = 8;
    localparam int unsigned W1 = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  v0, v1, c0, c1;
    logic [31:0] a0 [2];
    logic [31:0] b0 [2];
    logic [31:0] a1 [2];
    logic [31:0] b1 [2];
    logic [1:0]  r0, r1, rv, rid, rc, busy;
    logic [7:0]  rs8;
    logic [1:0]  rs2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state per DUT.
    int          left  [2];
    logic        lg    [2];
    logic [31:0] p_sum [2];
    logic [31:0] h_sum [2];
    logic        p_co  [2];
    logic        h_co  [2];
    logic        p_id  [2];
    logic        h_id  [2];

    serial_add_arbiter #(.WIDTH(W0)) u_dut8 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0[0]), .i_req0_a(a0[0][7:0]), .i_req0_b(b0[0][7:0]), .i_req0_cin(c0[0]),
        .o_req0_ready(r0[0]),
        .i_req1_valid(v1[0]), .i_req1_a(a1[0][7:0]), .i_req1_b(b1[0][7:0]), .i_req1_cin(c1[0]),
        .o_req1_ready(r1[0]),
        .o_res_valid(rv[0]), .o_res_id(rid[0]), .o_res_sum(rs8), .o_res_cout(rc[0]),
        .o_busy(busy[0])
    );

    serial_add_arbiter #(.WIDTH(W1)) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0[1]), .i_req0_a(a0[1][1:0]), .i_req0_b(b0[1][1:0]), .i_req0_cin(c0[1]),
        .o_req0_ready(r0[1]),
        .i_req1_valid(v1[1]), .i_req1_a(a1[1][1:0]), .i_req1_b(b1[1][1:0]), .i_req1_cin(c1[1]),
        .o_req1_ready(r1[1]),
        .o_res_valid(rv[1]), .o_res_id(rid[1]), .o_res_sum(rs2), .o_res_cout(rc[1]),
        .o_busy(busy[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait budget expired (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned wof(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    // Per-cycle compare against the model, then advance the model by one cycle.
    always @(negedge clk) begin
        logic [31:0] rs_d, a_sel, b_sel, mask;
        logic [63:0] full;
        logic        idle, g0, g1, cin_sel;
        int unsigned w;
        for (int d = 0; d < 2; d++) begin
            w    = wof(d);
            rs_d = (d == 0) ? 32'(rs8) : 32'(rs2);
            if (rst) begin
                left[d] = 0; lg[d] = 1'b1;
                h_sum[d] = '0; h_co[d] = 1'b0; h_id[d] = 1'b0;
                g0 = 1'b0; g1 = 1'b0;
            end else begin
                idle = (left[d] == 0);
                g0   = idle && v0[d] && (!v1[d] || lg[d]);
                g1   = idle && v1[d] && (!v0[d] || !lg[d]);
                if (left[d] == 1) begin
                    h_sum[d] = p_sum[d]; h_co[d] = p_co[d]; h_id[d] = p_id[d];
                end
            end
            chk($sformatf("d%0d ready0", d), 32'(r0[d]), 32'(g0));
            chk($sformatf("d%0d ready1", d), 32'(r1[d]), 32'(g1));
            chk($sformatf("d%0d res_valid", d), 32'(rv[d]), 32'(!rst && left[d] == 1));
            chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'(!rst && left[d] > 0));
            chk($sformatf("d%0d res_sum", d), rs_d, h_sum[d]);
            chk($sformatf("d%0d res_cout", d), 32'(rc[d]), 32'(h_co[d]));
            chk($sformatf("d%0d res_id", d), 32'(rid[d]), 32'(h_id[d]));
            if (!rst) begin
                if (left[d] > 0) begin
                    left[d]--;
                end else if (g0 || g1) begin
                    mask     = 32'((64'(1) << w) - 64'(1));
                    a_sel    = g1 ? a1[d] : a0[d];
                    b_sel    = g1 ? b1[d] : b0[d];
                    cin_sel  = g1 ? c1[d] : c0[d];
                    full     = 64'(a_sel & mask) + 64'(b_sel & mask) + 64'(cin_sel);
                    p_sum[d] = 32'(full) & mask;
                    p_co[d]  = full[w];
                    p_id[d]  = g1;
                    lg[d]    = g1;
                    left[d]  = int'(w) + 1;
                end
            end
        end
    end

    task automatic do_op(input int d, input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, output logic [31:0] s, output logic co,
                         output logic id, output int lat);
        bit got;
        int t0;
        s = '0; co = 1'b0; id = 1'b0; lat = -1;
        if (n == 0) begin v0[d] = 1'b1; a0[d] = a; b0[d] = b; c0[d] = cin; end
        else        begin v1[d] = 1'b1; a1[d] = a; b1[d] = b; c1[d] = cin; end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (n == 0) ? r0[d] : r1[d];
        end
        if (!got) begin
            fail("accept");
            v0[d] = 1'b0; v1[d] = 1'b0;
            return;
        end
        t0 = cyc;
        tick();
        // Drop valid and scramble operands; the captured copy must be used.
        v0[d] = 1'b0; v1[d] = 1'b0;
        a0[d] = $urandom; b0[d] = $urandom; a1[d] = $urandom; b1[d] = $urandom;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = rv[d];
        end
        if (!got) begin
            fail("result strobe");
            return;
        end
        lat = cyc - t0;
        s   = (d == 0) ? 32'(rs8) : 32'(rs2);
        co  = rc[d];
        id  = rid[d];
        tick();
    endtask

    // Both requesters on DUT0 stay valid; each drops only when served unless keep.
    task automatic contest(input int nres, input bit keep, output logic ids [8],
                           output logic [31:0] sums [8], output int cycs [8]);
        int  got;
        bit  clr0, clr1;
        for (int k = 0; k < 8; k++) begin ids[k] = 1'b0; sums[k] = '0; cycs[k] = 0; end
        got = 0;
        for (int i = 0; i < 200 && got < nres; i++) begin
            @(negedge clk);
            chk("ready exclusive", 32'(r0[0] & r1[0]), 32'd0);
            clr0 = r0[0] && !keep;
            clr1 = r1[0] && !keep;
            if (rv[0]) begin
                ids[got] = rid[0]; sums[got] = 32'(rs8); cycs[got] = cyc; got++;
            end
            tick();
            if (clr0) v0[0] = 1'b0;
            if (clr1) v1[0] = 1'b0;
        end
        if (got < nres) fail("contest results");
        v0[0] = 1'b0; v1[0] = 1'b0;
    endtask

    initial begin
        logic [31:0] s;
        logic        co, id;
        int          lat, strobes;
        logic        ids [8];
        logic [31:0] sums [8];
        int          cycs [8];

        rst = 1'b1;
        v0 = '0; v1 = '0; c0 = '0; c1 = '0;
        for (int d = 0; d < 2; d++) begin a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset res_valid", 32'(rv), 32'd0);
        chk("reset sum", 32'(rs8), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Simultaneous requests right after reset: req0 first.
        a0[0] = 32'd1;  b0[0] = 32'd2;  c0[0] = 1'b0; v0[0] = 1'b1;
        a1[0] = 32'd10; b1[0] = 32'd20; c1[0] = 1'b0; v1[0] = 1'b1;
        contest(2, 1'b0, ids, sums, cycs);
        chk("simul id0", 32'(ids[0]), 32'd0);
        chk("simul sum0", sums[0], 32'h03);
        chk("simul id1", 32'(ids[1]), 32'd1);
        chk("simul sum1", sums[1], 32'h1E);

        do_op(0, 0, 32'h3C, 32'h05, 1'b0, s, co, id, lat);
        chk("single sum", s, 32'h41);
        chk("single cout", 32'(co), 32'd0);
        chk("single id", 32'(id), 32'd0);
        chk("single latency", 32'(lat), 32'd9);

        do_op(0, 1, 32'hFF, 32'h00, 1'b1, s, co, id, lat);
        chk("ovf1 sum", s, 32'h00);
        chk("ovf1 cout", 32'(co), 32'd1);
        chk("ovf1 id", 32'(id), 32'd1);
        do_op(0, 1, 32'h80, 32'h7F, 1'b1, s, co, id, lat);
        chk("ovf2 sum", s, 32'h00);
        chk("ovf2 cout", 32'(co), 32'd1);

        // Fairness: continuous contention alternates grants.
        a0[0] = 32'h11; b0[0] = 32'h22; c0[0] = 1'b0; v0[0] = 1'b1;
        a1[0] = 32'h33; b1[0] = 32'h44; c1[0] = 1'b1; v1[0] = 1'b1;
        contest(6, 1'b1, ids, sums, cycs);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fair id%0d", k), 32'(ids[k]), 32'(k % 2));
            if (k > 0) chk($sformatf("fair gap%0d", k), 32'(cycs[k] - cycs[k-1]), 32'd10);
        end

        // Reset on the 4th ADD cycle aborts the operation.
        a0[0] = 32'h12; b0[0] = 32'h34; c0[0] = 1'b0; v0[0] = 1'b1;
        begin : mid_reset
            bit got;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                got = r0[0];
            end
            if (!got) fail("mid-reset accept");
        end
        repeat (4) tick();
        v0[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", 32'(busy[0]), 32'd0);
        chk("midrst res_valid", 32'(rv[0]), 32'd0);
        chk("midrst sum", 32'(rs8), 32'd0);
        tick();
        rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rv[0]) strobes++;
        end
        chk("midrst no strobe", 32'(strobes), 32'd0);
        tick();
        do_op(0, 1, 32'h55, 32'h2A, 1'b0, s, co, id, lat);
        chk("post-rst sum", s, 32'h7F);
        chk("post-rst id", 32'(id), 32'd1);
        a0[0] = 32'h01; b0[0] = 32'h01; c0[0] = 1'b0; v0[0] = 1'b1;
        a1[0] = 32'h02; b1[0] = 32'h02; c1[0] = 1'b0; v1[0] = 1'b1;
        contest(1, 1'b0, ids, sums, cycs);
        chk("post-rst contest id", 32'(ids[0]), 32'd0);
        repeat (12) tick();

        // Exhaustive WIDTH=2 on alternating requesters.
        for (int i = 0; i < 32; i++) begin
            logic [31:0] ea, eb;
            logic        ec;
            ea = 32'((i >> 3) & 3); eb = 32'((i >> 1) & 3); ec = i[0];
            do_op(1, i % 2, ea, eb, ec, s, co, id, lat);
            chk($sformatf("w2 %0d+%0d+%0d", ea, eb, ec), {29'd0, co, s[1:0]}, ea + eb + 32'(ec));
            chk($sformatf("w2 id %0d", i), 32'(id), 32'(i % 2));
            chk($sformatf("w2 latency %0d", i), 32'(lat), 32'd3);
        end

        // Random traffic on both DUTs; the model checks every cycle.
        for (int i = 0; i < 2500; i++) begin
            for (int d = 0; d < 2; d++) begin
                v0[d] = ($urandom_range(0, 2) != 0);
                v1[d] = ($urandom_range(0, 2) != 0);
                c0[d] = 1'($urandom_range(0, 1));
                c1[d] = 1'($urandom_range(0, 1));
                a0[d] = $urandom; b0[d] = $urandom;
                a1[d] = $urandom; b1[d] = $urandom;
            end
            tick();
        end
        v0 = '0; v1 = '0;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
